alu_trojan_monitor: RTL and testbench

ALU_TROJAN_MONITOR -- requirements
Module: alu_trojan_monitor

---
 rtl/alu_trojan_monitor.sv | 144 ++++++++++++++
 tb/tb_alu_trojan_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_trojan_monitor.sv
// Runtime Trojan monitor for a 4-bit ALU: a golden model runs beside the ALU under test,
// results are compared after DUT_LATENCY cycles, and repeated mismatches raise a sticky alarm.
module alu_trojan_monitor #(
    parameter int DUT_LATENCY  = 1,
    parameter int ALARM_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic [1:0]       op,
    input  logic [3:0]       dut_result,
    input  logic             dut_carry,
    input  logic             dut_zero,
    input  logic             dut_overflow,
    input  logic             clear,
    output logic             mismatch,
    output logic             alarm,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [1:0]       fail_op,
    output logic [3:0]       fail_A,
    output logic [3:0]       fail_B
);

    typedef enum logic [1:0] {
        CHECK   = 2'b00,
        SUSPECT = 2'b01,
        ALARM   = 2'b10
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       v;
    } pipe_t;

    localparam logic [3:0] THRESH = 4'(ALARM_THRESH);

    state_t     state_q, state_nxt;
    pipe_t      pipe [DUT_LATENCY];
    pipe_t      tail;
    logic [4:0] sum;
    logic       gold_c, gold_v;
    logic       do_cmp, fail, pass;
    logic [3:0] cons_q, cons_nxt;
    logic       captured_q;

    // Golden ALU evaluated on the stimulus as it is presented
    always_comb begin
        sum    = 5'd0;
        gold_c = 1'b0;
        gold_v = 1'b0;
        case (op)
            2'b00: begin
                sum    = {1'b0, A} + {1'b0, B};
                gold_c = sum[4];
                gold_v = (A[3] == B[3]) && (sum[3] != A[3]);
            end
            2'b01: begin
                sum    = {1'b0, A} + {1'b0, ~B} + 5'd1;
                gold_c = sum[4];
                gold_v = (A[3] != B[3]) && (sum[3] != A[3]);
            end
            2'b10:   sum = {1'b0, A & B};
            default: sum = {1'b0, A | B};
        endcase
    end

    // Valid-tagged delay line; in-flight entries are dropped on reset but survive clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DUT_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{vld: in_valid, op: op, a: A, b: B, res: sum[3:0],
                         c: gold_c, z: (sum[3:0] == 4'h0), v: gold_v};
            for (int i = 1; i < DUT_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail   = pipe[DUT_LATENCY-1];
    assign do_cmp = tail.vld && !clear;
    assign fail   = do_cmp && ({dut_result, dut_carry, dut_zero, dut_overflow}
                               != {tail.res, tail.c, tail.z, tail.v});
    assign pass   = do_cmp && !fail;

    always_comb begin
        cons_nxt = cons_q;
        if (fail)      cons_nxt = (cons_q == 4'hF) ? 4'hF : cons_q + 4'd1;
        else if (pass) cons_nxt = 4'd0;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            CHECK, SUSPECT: begin
                if (fail)      state_nxt = (cons_nxt >= THRESH) ? ALARM : SUSPECT;
                else if (pass) state_nxt = CHECK;
            end
            ALARM:   state_nxt = ALARM;
            default: state_nxt = CHECK;
        endcase
        if (clear) state_nxt = CHECK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= CHECK;
        else        state_q <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
            cons_q       <= 4'd0;
            captured_q   <= 1'b0;
            fail_op      <= 2'b00;
            fail_A       <= 4'h0;
            fail_B       <= 4'h0;
        end else begin
            mismatch <= fail;
            cons_q   <= cons_nxt;
            if (fail && (mismatch_cnt != {CNT_W{1'b1}})) mismatch_cnt <= mismatch_cnt + 1'b1;
            // Only the first failing stimulus is kept for post-mortem
            if (fail && !captured_q) begin
                captured_q <= 1'b1;
                fail_op    <= tail.op;
                fail_A     <= tail.a;
                fail_B     <= tail.b;
            end
        end
    end

    assign state = state_q;
    assign alarm = (state_q == ALARM);

endmodule

// File: tb/tb_alu_trojan_monitor.sv
// Randomized bench: a behavioural ALU with optional fault injection feeds the monitor,
// and a queue-based scoreboard predicts every monitor output cycle by cycle.
module tb_alu_trojan_monitor;

    localparam int L     = 3;
    localparam int TH    = 3;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [3:0]    A = 4'h0, B = 4'h0;
    logic [1:0]    op = 2'b00;
    logic [3:0]    dut_result = 4'h0;
    logic          dut_carry = 1'b0, dut_zero = 1'b0, dut_overflow = 1'b0;
    logic          clear = 1'b0;
    logic          mismatch, alarm;
    logic [1:0]    state;
    logic [CW-1:0] mismatch_cnt;
    logic [1:0]    fail_op;
    logic [3:0]    fail_A, fail_B;

    alu_trojan_monitor #(.DUT_LATENCY(L), .ALARM_THRESH(TH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .op(op),
        .dut_result(dut_result), .dut_carry(dut_carry), .dut_zero(dut_zero),
        .dut_overflow(dut_overflow), .clear(clear), .mismatch(mismatch), .alarm(alarm),
        .state(state), .mismatch_cnt(mismatch_cnt), .fail_op(fail_op), .fail_A(fail_A),
        .fail_B(fail_B)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int         due;
        bit         fault;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t       exp_q[$];
    bit         clr_at[int];
    bit         rst_at[int];
    logic [6:0] resp_ring[16];
    int         total = 0;
    int         bad = 0;

    // reference monitor state, plain integers
    int         m_state = 0;
    int         m_cons = 0;
    int         m_cnt = 0;
    bit         m_have = 0;
    int         m_fop = 0, m_fa = 0, m_fb = 0;

    // Behavioural ALU: {result[3:0], carry, zero, overflow}
    function automatic logic [6:0] gold(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r, s;
        bit c, v;
        logic [3:0] res;
        ua = a; ub = b;
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        c = 0; v = 0;
        case (o)
            2'd0: begin r = ua + ub; c = (r > 15);    s = sa + sb; v = (s > 7) || (s < -8); end
            2'd1: begin r = ua - ub; c = (ua >= ub);  s = sa - sb; v = (s > 7) || (s < -8); end
            2'd2: r = ua & ub;
            default: r = ua | ub;
        endcase
        res = 4'(r & 15);
        return {res, c, (res == 4'h0), v};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit v, input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [6:0] flip, input bit clr, input bit rst);
        int c;
        logic [6:0] r;
        exp_t e;
        exp_t keep[$];
        @(posedge clk);
        #1;
        c = cyc;
        rst_n    = !rst;
        clear    = clr;
        in_valid = v;
        op       = v ? o : 2'($urandom_range(0, 3));
        A        = v ? a : 4'($urandom_range(0, 15));
        B        = v ? b : 4'($urandom_range(0, 15));
        r = v ? (gold(op, A, B) ^ flip) : 7'($urandom_range(0, 127));
        resp_ring[c % 16] = r;
        r = (c >= L) ? resp_ring[(c - L) % 16] : 7'($urandom_range(0, 127));
        {dut_result, dut_carry, dut_zero, dut_overflow} = r;
        if (clr) clr_at[c] = 1;
        if (rst) begin
            rst_at[c] = 1;
            foreach (exp_q[i]) if (exp_q[i].due <= c) keep.push_back(exp_q[i]);
            exp_q = keep;
        end else if (v) begin
            e.due = c + L + 1; e.fault = (flip != 7'd0); e.op = o; e.a = a; e.b = b;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'd0, 4'd0, 4'd0, 7'd0, 0, 0);
    endtask

    task automatic rnd_valid(input int fault_pct, input bit clr);
        logic [6:0] f;
        f = ($urandom_range(0, 99) < fault_pct) ? 7'(1 << $urandom_range(0, 6)) : 7'd0;
        step(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             f, clr, 0);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int n;
        bit m_mis;
        bit wipe;
        exp_t e;
        n = cyc;
        m_mis = 0;
        wipe = clr_at.exists(n - 1) || rst_at.exists(n - 1);
        if (exp_q.size() > 0 && exp_q[0].due == n) begin
            e = exp_q.pop_front();
            if (!wipe) begin
                if (e.fault) begin
                    m_mis = 1;
                    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                    m_cons++;
                    if (m_state != 2) m_state = (m_cons >= TH) ? 2 : 1;
                    if (!m_have) begin
                        m_have = 1; m_fop = e.op; m_fa = e.a; m_fb = e.b;
                    end
                end else begin
                    m_cons = 0;
                    if (m_state != 2) m_state = 0;
                end
            end
        end
        if (wipe) begin
            m_state = 0; m_cons = 0; m_cnt = 0; m_have = 0;
            m_fop = 0; m_fa = 0; m_fb = 0;
        end
        if (n >= 1) begin
            chk("mismatch", int'(mismatch), int'(m_mis));
            chk("state", int'(state), m_state);
            chk("alarm", int'(alarm), int'(m_state == 2));
            chk("mismatch_cnt", int'(mismatch_cnt), m_cnt);
            chk("fail_op", int'(fail_op), m_fop);
            chk("fail_A", int'(fail_A), m_fa);
            chk("fail_B", int'(fail_B), m_fb);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_at[0] = 1;
        for (int i = 0; i < 3; i++) step(0, 2'd0, 4'd0, 4'd0, 7'd0, 0, 1);
        idle(2);

        // known-answer vectors through a correct ALU
        step(1, 2'd0, 4'd7, 4'd9, 7'd0, 0, 0);
        step(1, 2'd0, 4'd7, 4'd1, 7'd0, 0, 0);
        step(1, 2'd1, 4'd3, 4'd5, 7'd0, 0, 0);
        idle(L + 2);

        // Trojan: AND with A=F flips result bit 0, three times in a row
        for (int i = 0; i < 3; i++) step(1, 2'd2, 4'hF, 4'($urandom_range(0, 15)), 7'b0001000, 0, 0);
        idle(L + 2);

        // failing compare in ALARM coincides with clear
        step(1, 2'd3, 4'hF, 4'h2, 7'b0000100, 0, 0);
        idle(L - 1);
        step(0, 2'd0, 4'd0, 4'd0, 7'd0, 1, 0);
        idle(L + 2);

        // alternating fail/pass
        for (int i = 0; i < 10; i++)
            step(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 (i % 2 == 0) ? 7'b1000000 : 7'd0, 0, 0);
        idle(L + 2);
        step(0, 2'd0, 4'd0, 4'd0, 7'd0, 1, 0);

        // random gaps against a correct ALU, then with faults and occasional clear
        for (int i = 0; i < 150; i++) begin
            idle($urandom_range(0, 2));
            rnd_valid(0, 0);
        end
        for (int i = 0; i < 200; i++) begin
            idle($urandom_range(0, 2));
            rnd_valid(30, ($urandom_range(0, 39) == 0));
        end

        // reset with stimulus in flight
        rnd_valid(60, 0);
        rnd_valid(60, 0);
        step(1, 2'd0, 4'd1, 4'd1, 7'b1111111, 0, 1);
        for (int i = 0; i < 20; i++) rnd_valid(25, 0);
        idle(L + 2);

        // counter saturation
        step(0, 2'd0, 4'd0, 4'd0, 7'd0, 1, 0);
        for (int i = 0; i < 12; i++) rnd_valid(100, 0);
        idle(L + 3);

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
